// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package mdu_pkg;

    localparam int unsigned DEFAULT_XLEN = 32;

    typedef enum logic [2:0] {
        OpMul    = 3'b000,
        OpMulh   = 3'b001,
        OpMulhsu = 3'b010,
        OpMulhu  = 3'b011,
        OpDiv    = 3'b100,
        OpDivu   = 3'b101,
        OpRem    = 3'b110,
        OpRemu   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } mdu_state_e;

    localparam logic [DEFAULT_XLEN-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/mdu_operand_prep.sv
// Operand magnitudes, result sign flags and divide special-case detection for mdu_iter.
module mdu_operand_prep
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = DEFAULT_XLEN
) (
    input  mdu_op_e         op_i,
    input  logic [XLEN-1:0] opr_a_i,
    input  logic [XLEN-1:0] opr_b_i,
    output logic [XLEN-1:0] mag_a_o,
    output logic [XLEN-1:0] mag_b_o,
    output logic            qneg_o,
    output logic            rneg_o,
    output logic            div_zero_o,
    output logic            div_ovf_o
);

    logic signed_a;
    logic signed_b;
    logic sign_a;
    logic sign_b;
    logic is_div;

    always_comb begin
        signed_a = 1'b0;
        signed_b = 1'b0;
        case (op_i)
            OpMulh, OpDiv, OpRem: begin
                signed_a = 1'b1;
                signed_b = 1'b1;
            end
            OpMulhsu: signed_a = 1'b1;
            default: ;
        endcase
    end

    assign is_div = op_i[2];
    assign sign_a = signed_a & opr_a_i[XLEN-1];
    assign sign_b = signed_b & opr_b_i[XLEN-1];

    // Most-negative value maps onto itself, which is the correct unsigned magnitude.
    assign mag_a_o = sign_a ? -opr_a_i : opr_a_i;
    assign mag_b_o = sign_b ? -opr_b_i : opr_b_i;

    assign qneg_o = sign_a ^ sign_b;
    assign rneg_o = sign_a;

    assign div_zero_o = is_div & (opr_b_i == '0);
    assign div_ovf_o  = is_div & signed_a & (opr_a_i == {1'b1, {(XLEN-1){1'b0}}})
                        & (&opr_b_i);

endmodule

// File: rtl/mdu_iter.sv
// Iterative radix-2 RV32M multiply/divide unit; one step per cycle, XLEN steps per op.
// Optional MDU_MUL_EARLY_OUT_EN: multiplies leave CALC once the multiplier is exhausted.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = DEFAULT_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] opr_a_i,
    input  logic [XLEN-1:0] opr_b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [5:0]      LastStep = 6'(XLEN - 1);
    localparam logic [XLEN-1:0] DivZeroQ = {XLEN{DIV_ZERO_Q[0]}};

    mdu_state_e        state_q;
    mdu_op_e           op_q;
    logic              qneg_q;
    logic              rneg_q;
    logic [5:0]        step_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic              busy_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    mdu_op_e         op_in;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            qneg;
    logic            rneg;
    logic            div_zero;
    logic            div_ovf;

    assign op_in = mdu_op_e'(funct3_i);

    mdu_operand_prep #(
        .XLEN (XLEN)
    ) u_prep (
        .op_i       (op_in),
        .opr_a_i    (opr_a_i),
        .opr_b_i    (opr_b_i),
        .mag_a_o    (mag_a),
        .mag_b_o    (mag_b),
        .qneg_o     (qneg),
        .rneg_o     (rneg),
        .div_zero_o (div_zero),
        .div_ovf_o  (div_ovf)
    );

    logic              is_mul;
    logic              calc_last;
    logic [2*XLEN-1:0] mul_acc;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_acc;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fix_result;
    logic [XLEN-1:0]   fast_result;

    assign is_mul = ~op_q[2];

`ifdef MDU_MUL_EARLY_OUT_EN
    assign calc_last = (step_q == LastStep) || (is_mul && (mplier_q[XLEN-1:1] == '0));
`else
    assign calc_last = (step_q == LastStep);
`endif

    // Divide keeps {remainder, dividend/quotient} in acc_q; divisor sits in mcand_q low half.
    always_comb begin
        mul_acc   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = rem_shift - {1'b0, mcand_q[XLEN-1:0]};
        if (div_diff[XLEN]) begin
            div_acc = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            div_acc = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
    end

    always_comb begin
        prod = qneg_q ? -acc_q : acc_q;
        quot = qneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            OpMul:                    fix_result = prod[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu: fix_result = prod[2*XLEN-1:XLEN];
            OpDiv, OpDivu:            fix_result = quot;
            default:                  fix_result = rem;
        endcase
    end

    always_comb begin
        if (div_zero) begin
            fast_result = op_in[1] ? opr_a_i : DivZeroQ;
        end else begin
            fast_result = op_in[1] ? '0 : opr_a_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            op_q     <= OpMul;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            step_q   <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                    if (start_i) begin
                        op_q   <= op_in;
                        qneg_q <= qneg;
                        rneg_q <= rneg;
                        step_q <= '0;
                        if (div_zero || div_ovf) begin
                            state_q  <= StDone;
                            done_q   <= 1'b1;
                            result_q <= fast_result;
                        end else begin
                            state_q  <= StCalc;
                            busy_q   <= 1'b1;
                            mplier_q <= mag_b;
                            mcand_q  <= {{XLEN{1'b0}}, op_in[2] ? mag_b : mag_a};
                            acc_q    <= op_in[2] ? {{XLEN{1'b0}}, mag_a} : '0;
                        end
                    end
                end
                StCalc: begin
                    step_q <= step_q + 6'd1;
                    if (is_mul) begin
                        acc_q    <= mul_acc;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                    end else begin
                        acc_q <= div_acc;
                    end
                    if (calc_last) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    state_q  <= StDone;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    result_q <= fix_result;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: vector table, random model ops and multi-cycle corner cases.
module tb_mdu_iter;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] opr_a_i;
    logic [31:0] opr_b_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    mdu_iter #(
        .XLEN (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .funct3_i (funct3_i),
        .opr_a_i  (opr_a_i),
        .opr_b_i  (opr_b_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] val;
        string       name;
    } exp_t;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails = 0;
    bit   overlap = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endfunction

    // Reference latency in cycles from the start cycle to the done_o cycle.
    function automatic int exp_latency(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        logic [31:0] mb;
        int          msb;
        mb  = b;
        msb = -1;
        if (f[2] && ((b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hffff_ffff))) begin
            return 1;
        end
`ifdef MDU_MUL_EARLY_OUT_EN
        if (!f[2]) begin
            if (f == 3'b001 && b[31]) mb = -b;
            for (int i = 0; i < 32; i++) if (mb[i]) msb = i;
            return 2 + ((msb + 1) < 1 ? 1 : msb + 1);
        end
`endif
        return 34;
    endfunction

    function automatic logic [31:0] model(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] ub;
        logic signed [63:0] p;
        logic        [63:0] up;
        logic signed [31:0] sa32;
        logic signed [31:0] sb32;
        logic        [31:0] r;
        sa   = {{32{a[31]}}, a};
        sb   = {{32{b[31]}}, b};
        ub   = {32'd0, b};
        sa32 = a;
        sb32 = b;
        r    = 32'd0;
        case (f)
            3'b000: r = a * b;
            3'b001: begin p = sa * sb; r = p[63:32]; end
            3'b010: begin p = sa * ub; r = p[63:32]; end
            3'b011: begin up = {32'd0, a} * {32'd0, b}; r = up[63:32]; end
            3'b100: begin
                if (b == 0) r = 32'hffff_ffff;
                else if (a == 32'h8000_0000 && b == 32'hffff_ffff) r = a;
                else r = sa32 / sb32;
            end
            3'b101: r = (b == 0) ? 32'hffff_ffff : a / b;
            3'b110: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hffff_ffff) r = 32'd0;
                else r = sa32 % sb32;
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Scoreboard: every done_o pops one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (busy_o && done_o) overlap = 1'b1;
        if (rst && done_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL spurious_done: got result %08h expected no done_o", result_o);
            end else begin
                e = exp_q.pop_front();
                check(e.name, result_o, e.val);
            end
        end
    end

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] req, input string name);
        int lat;
        int s;
        int d;
        int busy_bad;
        lat = exp_latency(f, a, b);
        @(posedge clk); #1;
        start_i  = 1'b1;
        funct3_i = f;
        opr_a_i  = a;
        opr_b_i  = b;
        s        = cyc;
        exp_q.push_back('{req, name});
        @(posedge clk); #1;
        start_i  = 1'b0;
        funct3_i = 3'($urandom_range(0, 7));
        opr_a_i  = $urandom;
        opr_b_i  = $urandom;
        d        = -1;
        busy_bad = 0;
        for (int n = 0; n < 100 && d < 0; n++) begin
            @(negedge clk);
            if (busy_o !== ((cyc - s) >= 1 && (cyc - s) < lat)) busy_bad++;
            if (done_o) d = cyc - s;
        end
        check({name, "_latency"}, 32'(d), 32'(lat));
        check({name, "_busy"}, 32'(busy_bad), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check({name, "_hold"}, result_o, req);
    endtask

    task automatic wait_done(output int at);
        at = -1;
        for (int n = 0; n < 200 && at < 0; n++) begin
            @(negedge clk);
            if (done_o) at = cyc;
        end
    endtask

    vec_t vecs[17];

    initial begin
        int s;
        int d;
        int lat;
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0]  = '{3'b000, 32'd7,          32'd6,          32'd42,         "mul_7x6"};
        vecs[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  "mulh_min"};
        vecs[2]  = '{3'b011, 32'hffff_ffff,  32'hffff_ffff,  32'hffff_fffe,  "mulhu_max"};
        vecs[3]  = '{3'b010, 32'hffff_ffff,  32'd2,          32'hffff_ffff,  "mulhsu_neg"};
        vecs[4]  = '{3'b010, 32'd2,          32'hffff_ffff,  32'd1,          "mulhsu_ub"};
        vecs[5]  = '{3'b000, 32'hffff_ffff,  32'hffff_ffff,  32'd1,          "mul_m1"};
        vecs[6]  = '{3'b100, 32'hffff_fff9,  32'd2,          32'hffff_fffd,  "div_m7_2"};
        vecs[7]  = '{3'b110, 32'hffff_fff9,  32'd2,          32'hffff_ffff,  "rem_m7_2"};
        vecs[8]  = '{3'b100, 32'd7,          32'hffff_fffe,  32'hffff_fffd,  "div_7_m2"};
        vecs[9]  = '{3'b110, 32'd7,          32'hffff_fffe,  32'd1,          "rem_7_m2"};
        vecs[10] = '{3'b101, 32'd100,        32'd7,          32'd14,         "divu_100_7"};
        vecs[11] = '{3'b111, 32'd100,        32'd7,          32'd2,          "remu_100_7"};
        vecs[12] = '{3'b101, 32'd5,          32'd0,          32'hffff_ffff,  "divu_by0"};
        vecs[13] = '{3'b110, 32'd5,          32'd0,          32'd5,          "rem_by0"};
        vecs[14] = '{3'b100, 32'h8000_0000,  32'hffff_ffff,  32'h8000_0000,  "div_ovf"};
        vecs[15] = '{3'b110, 32'h8000_0000,  32'hffff_ffff,  32'd0,          "rem_ovf"};
        vecs[16] = '{3'b000, 32'd100,        32'd3,          32'd300,        "mul_100x3"};

        rst      = 1'b0;
        start_i  = 1'b0;
        funct3_i = 3'b000;
        opr_a_i  = 32'd0;
        opr_b_i  = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_done", 32'(done_o), 32'd0);
        check("reset_result", result_o, 32'd0);
        #1 rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
        end

        for (int i = 0; i < 10; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            run_op(rf, ra, rb, model(rf, ra, rb), $sformatf("rand%0d_f%0d", i, rf));
        end

        // A second start during CALC must be ignored.
        lat = exp_latency(3'b000, 32'd4, 32'h4000_0003);
        @(posedge clk); #1;
        start_i  = 1'b1;
        funct3_i = 3'b000;
        opr_a_i  = 32'd4;
        opr_b_i  = 32'h4000_0003;
        s        = cyc;
        exp_q.push_back('{32'd12, "ignore_start_result"});
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        start_i  = 1'b1;
        funct3_i = 3'b100;
        opr_a_i  = 32'd77;
        opr_b_i  = 32'd7;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_done(d);
        check("ignore_start_latency", 32'(d - s), 32'(lat));
        repeat (40) @(negedge clk);

        // Reset mid-CALC discards the op with no done_o.
        @(posedge clk); #1;
        start_i  = 1'b1;
        funct3_i = 3'b101;
        opr_a_i  = 32'd1000;
        opr_b_i  = 32'd3;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (19) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("midreset_busy", 32'(busy_o), 32'd0);
        check("midreset_done", 32'(done_o), 32'd0);
        check("midreset_result", result_o, 32'd0);
        repeat (40) @(negedge clk);
        run_op(3'b101, 32'd1000, 32'd3, 32'd333, "after_reset_divu");

        // start_i held high through DONE launches the next op with no IDLE cycle.
        lat = exp_latency(3'b000, 32'd5, 32'd6);
        @(posedge clk); #1;
        start_i  = 1'b1;
        funct3_i = 3'b000;
        opr_a_i  = 32'd5;
        opr_b_i  = 32'd6;
        s        = cyc;
        exp_q.push_back('{32'd30, "b2b_first"});
        exp_q.push_back('{32'd10, "b2b_second"});
        @(posedge clk); #1;
        funct3_i = 3'b101;
        opr_a_i  = 32'd50;
        opr_b_i  = 32'd5;
        wait_done(d);
        check("b2b_first_latency", 32'(d - s), 32'(lat));
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        check("b2b_busy_next", 32'(busy_o), 32'd1);
        wait_done(d);
        check("b2b_second_latency", 32'(d - s), 32'(lat + 34));
        repeat (3) @(negedge clk);

        check("busy_done_overlap", 32'(overlap), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, in parallel with the ALU.
- Consumes the same register-file operands as the ALU (rs1 → opr_a_i, rs2 → opr_b_i).
- Produces a result for the writeback select mux.
- Holds busy_o high while computing so the processor stalls PC update and register write until done_o.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-low; takes effect on the rising clk edge while low.
- start_i  input  1  request; sampled only in IDLE or DONE.
- funct3_i  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- opr_a_i  input  XLEN  rs1 value; captured with start_i.
- opr_b_i  input  XLEN  rs2 value; captured with start_i.
- busy_o  output  1  high while an accepted op is in flight (CALC/FIX).
- done_o  output  1  one-cycle pulse; result_o valid in this cycle.
- result_o  output  XLEN  result; held stable from done_o until the next accepted start.

Behaviour:
Reset:
- rst low at an edge forces state IDLE and busy_o=0, done_o=0, result_o=0.
- Applies at any point, including mid-CALC; the in-flight op is discarded with no done_o.

FSM states: IDLE, CALC, FIX, DONE.
- IDLE + start_i → CALC. Operands, op and sign flags are latched. Signed operands are converted to magnitudes.
- CALC: one radix-2 step per cycle for XLEN cycles, driven by a 6-bit step counter.
  - Multiply: shift-add into a 2*XLEN-bit product register.
  - Divide: restoring shift-subtract producing XLEN-bit quotient and remainder.
- FIX (1 cycle): applies sign correction and selects the output.
  - MUL: product[XLEN-1:0].
  - MULH*: product[2*XLEN-1:XLEN].
  - DIV*: quotient.
  - REM*: remainder.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - MULHSU treats a as signed and b as unsigned.
- DONE: done_o=1 for one cycle, then → IDLE. If start_i is high in DONE, go directly to CALC (back-to-back ops).

Latency:
- Start sampled at end of cycle 0; done_o asserted in cycle XLEN+2 (34 for XLEN=32).
- busy_o is high in cycles 1..XLEN+1 and low in DONE.

Fast path (IDLE/DONE → DONE directly; done_o in cycle 1, busy_o never asserted):
- Divide by zero: DIV/DIVU → all-ones; REM/REMU → opr_a_i.
- Signed overflow (DIV with a=0x80000000, b=0xFFFFFFFF): DIV → 0x80000000; REM → 0.

Handshake and boundaries:
- start_i while busy_o=1 is ignored. Operand changes during CALC have no effect.
- Unknown funct3 cannot occur (3-bit fully decoded).
- done_o and busy_o are never high simultaneously.
- All arithmetic is modulo 2^XLEN except the 2*XLEN product register. Counter terminal compare is step==XLEN-1.

Optional Feature:
- Macro MDU_MUL_EARLY_OUT_EN.
- Defined: for MUL* ops, CALC exits to FIX once the remaining multiplier-magnitude register is zero (minimum 1 CALC cycle). Latency = 2 + max(1, msb_index(|b|)+1). Divide latency is unchanged.
- Undefined: all multiplies take exactly XLEN CALC cycles; no early-exit logic is synthesised.

Decomposition:
- Package mdu_pkg holds:
  - XLEN default constant.
  - mdu_op_e enum (8 funct3 encodings).
  - mdu_state_e enum (IDLE, CALC, FIX, DONE).
  - DIV_ZERO_Q constant (all-ones).
- One sub-module, mdu_operand_prep (combinational), produces operand magnitudes and sign flags from op/opr_a/opr_b. It is reused for the fast-path special-case detection.

Test Plan:
1. MUL a=7, b=6, start in cycle 0 → busy_o in cycles 1..33, done_o in cycle 34, result_o=42 and held until the next start.
2. MULH a=b=0x80000000 → 0x40000000. MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
3. DIV a=0xFFFFFFF9 (-7), b=2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
4. DIVU a=5, b=0 → done_o in cycle 1, result 0xFFFFFFFF. REM a=5, b=0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same → 0. busy_o stays 0 throughout.
5. Start MUL 3*4; pulse start_i with DIV at cycle 10 → ignored, result 12 at cycle 34. Drive rst low at cycle 20 of a second op → next cycle busy_o=0, result_o=0, no done_o. A following start then completes normally.
6. With MDU_MUL_EARLY_OUT_EN: MUL 100*3 → done_o in cycle 4, result 300. Without the macro → cycle 34, result 300. Back-to-back: start held high in DONE launches the next op with no IDLE cycle.
